dynode_energy_int: RTL and testbench

- Downstream consumer of the dynode baseline stage in the ROCSTAR dynode trigger path.
- Takes the delayed dynode ADC stream and the 8.8 fixed-point running baseline.
- On each dynode event it integrates a programmable number of samples, subtracts the baseline latched at integration start, and emits one baseline-corrected energy word with a valid strobe and a pileup flag.

---
 rtl/dynode_energy_int.sv | 203 ++++++++++++++++++++
 tb/tb_dynode_energy_int.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dynode_energy_int.sv
// Dynode energy integrator: after each dynode event edge, sums a programmable window of
// delayed ADC samples, removes the latched baseline and emits a 14.2 energy word.
module dynode_energy_int #(
   parameter int EWIDTH = 16,
   parameter int CWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        dyn_adcdly,
   input  logic [15:0]       dyn_curval,
   input  logic              dyn_event,
   input  logic              dyn_pileup,
   input  logic              dyn_pudump,
   input  logic [3:0]        intdly,
   input  logic [5:0]        intlen,
   output logic              ene_valid,
   output logic [EWIDTH-1:0] ene_value,
   output logic              ene_pileup,
   output logic              ene_drop,
   output logic              ene_busy,
   output logic [CWIDTH-1:0] evt_cnt,
   output logic [CWIDTH-1:0] drop_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_INTEG = 3'd2;
   localparam logic [2:0] S_CALC1 = 3'd3;
   localparam logic [2:0] S_CALC2 = 3'd4;
   localparam logic [2:0] S_OUT   = 3'd5;

   // Two-stage edge detect: input seen at edge k yields a rise acted on at edge k+1.
   logic ev_q, ev_qq, pu_q, pu_qq, pd_q, pd_qq;
   logic ev_rise, pu_rise, pd_rise;

   logic [2:0]        state_q, state_d;
   logic [3:0]        dly_q, dly_d;
   logic [5:0]        rem_q, rem_d;
   logic [5:0]        len_q, len_d;
   logic [13:0]       acc_q, acc_d;
   logic [15:0]       bl_q, bl_d;
   logic              pile_q, pile_d;
   logic [21:0]       prod_a_q, prod_a_d;
   logic [21:0]       prod_b_q, prod_b_d;
   logic [EWIDTH-1:0] res_q, res_d;
   logic              valid_q, valid_d;
   logic              drop_q, drop_d;
   logic [EWIDTH-1:0] value_q, value_d;
   logic              epu_q, epu_d;
   logic [CWIDTH-1:0] evt_q, evt_d;
   logic [CWIDTH-1:0] dropc_q, dropc_d;
   logic              first_smp, abort;
   logic [23:0]       corr_w;
   logic              corr_unused;

   assign ev_rise = ev_q & ~ev_qq;
   assign pu_rise = pu_q & ~pu_qq;
   assign pd_rise = pd_q & ~pd_qq;

   // Signed 24-bit difference; bit 23 is the sign, bits 21:6 are the 14.2 result.
   assign corr_w      = {2'b00, prod_a_q} - {2'b00, prod_b_q};
   assign corr_unused = ^{corr_w[22], corr_w[5:0]};

   always_comb begin
      state_d   = state_q;
      dly_d     = dly_q;
      rem_d     = rem_q;
      len_d     = len_q;
      acc_d     = acc_q;
      bl_d      = bl_q;
      pile_d    = pile_q;
      prod_a_d  = prod_a_q;
      prod_b_d  = prod_b_q;
      res_d     = res_q;
      valid_d   = 1'b0;
      drop_d    = 1'b0;
      value_d   = value_q;
      epu_d     = epu_q;
      evt_d     = evt_q;
      dropc_d   = dropc_q;
      first_smp = 1'b0;
      abort     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ev_rise && intlen != 6'd0) begin
               len_d  = intlen;
               pile_d = 1'b0;
               dly_d  = intdly;
               if (intdly == 4'd0) first_smp = 1'b1;
               else                state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (pd_rise) abort = 1'b1;
            else begin
               if (ev_rise || pu_rise) pile_d = 1'b1;
               if (dly_q == 4'd1) first_smp = 1'b1;
               else               dly_d     = dly_q - 4'd1;
            end
         end
         S_INTEG: begin
            if (pd_rise) abort = 1'b1;
            else begin
               if (ev_rise || pu_rise) pile_d = 1'b1;
               acc_d = acc_q + {6'b0, dyn_adcdly};
               rem_d = rem_q - 6'd1;
               if (rem_q == 6'd1) state_d = S_CALC1;
            end
         end
         S_CALC1: begin
            if (ev_rise || pu_rise) pile_d = 1'b1;
            prod_a_d = {acc_q, 8'b0};
            prod_b_d = 22'(len_q) * 22'(bl_q);
            state_d  = S_CALC2;
         end
         S_CALC2: begin
            if (ev_rise || pu_rise) pile_d = 1'b1;
            res_d   = corr_w[23] ? '0 : EWIDTH'(corr_w[21:6]);
            state_d = S_OUT;
         end
         S_OUT: begin
            valid_d = 1'b1;
            value_d = res_q;
            epu_d   = pile_q;
            evt_d   = evt_q + CWIDTH'(1);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // First integrated sample also captures the baseline used for the whole window.
      if (first_smp) begin
         acc_d   = {6'b0, dyn_adcdly};
         bl_d    = dyn_curval;
         rem_d   = len_d - 6'd1;
         state_d = (len_d == 6'd1) ? S_CALC1 : S_INTEG;
      end
      if (abort) begin
         state_d = S_IDLE;
         drop_d  = 1'b1;
         dropc_d = dropc_q + CWIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_q     <= 1'b0;
         ev_qq    <= 1'b0;
         pu_q     <= 1'b0;
         pu_qq    <= 1'b0;
         pd_q     <= 1'b0;
         pd_qq    <= 1'b0;
         state_q  <= S_IDLE;
         dly_q    <= '0;
         rem_q    <= '0;
         len_q    <= '0;
         acc_q    <= '0;
         bl_q     <= '0;
         pile_q   <= 1'b0;
         prod_a_q <= '0;
         prod_b_q <= '0;
         res_q    <= '0;
         valid_q  <= 1'b0;
         drop_q   <= 1'b0;
         value_q  <= '0;
         epu_q    <= 1'b0;
         evt_q    <= '0;
         dropc_q  <= '0;
      end else begin
         ev_q     <= dyn_event;
         ev_qq    <= ev_q;
         pu_q     <= dyn_pileup;
         pu_qq    <= pu_q;
         pd_q     <= dyn_pudump;
         pd_qq    <= pd_q;
         state_q  <= state_d;
         dly_q    <= dly_d;
         rem_q    <= rem_d;
         len_q    <= len_d;
         acc_q    <= acc_d;
         bl_q     <= bl_d;
         pile_q   <= pile_d;
         prod_a_q <= prod_a_d;
         prod_b_q <= prod_b_d;
         res_q    <= res_d;
         valid_q  <= valid_d;
         drop_q   <= drop_d;
         value_q  <= value_d;
         epu_q    <= epu_d;
         evt_q    <= evt_d;
         dropc_q  <= dropc_d;
      end
   end

   // ene_valid and ene_drop are single-cycle strobes with no backpressure.
   assign ene_valid  = valid_q;
   assign ene_value  = value_q;
   assign ene_pileup = epu_q;
   assign ene_drop   = drop_q;
   assign ene_busy   = (state_q != S_IDLE);
   assign evt_cnt    = evt_q;
   assign drop_cnt   = dropc_q;

endmodule

// File: tb/tb_dynode_energy_int.sv
// Bench for dynode_energy_int: event-level reference model checked every cycle,
// directed scenarios with hand-computed results, then randomized traffic.
module tb_dynode_energy_int;
   localparam int EW   = 16;
   localparam int CW   = 8;
   localparam int MAXC = 8192;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    dyn_adcdly = '0;
   logic [15:0]   dyn_curval = '0;
   logic          dyn_event = 1'b0;
   logic          dyn_pileup = 1'b0;
   logic          dyn_pudump = 1'b0;
   logic [3:0]    intdly = '0;
   logic [5:0]    intlen = '0;
   logic          ene_valid, ene_pileup, ene_drop, ene_busy;
   logic [EW-1:0] ene_value;
   logic [CW-1:0] evt_cnt, drop_cnt;

   always #5 clk = ~clk;

   dynode_energy_int #(.EWIDTH(EW), .CWIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .dyn_adcdly(dyn_adcdly), .dyn_curval(dyn_curval),
      .dyn_event(dyn_event), .dyn_pileup(dyn_pileup), .dyn_pudump(dyn_pudump),
      .intdly(intdly), .intlen(intlen),
      .ene_valid(ene_valid), .ene_value(ene_value), .ene_pileup(ene_pileup),
      .ene_drop(ene_drop), .ene_busy(ene_busy),
      .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
   );

   int tests = 0;
   int fails = 0;
   int m = 0;

   // Input log per clock edge; flags are {pudump, pileup, event}, forced 0 under reset.
   logic [2:0]  flg_l [MAXC];
   logic [7:0]  adc_l [MAXC];
   logic [15:0] bl_l  [MAXC];
   logic [3:0]  dly_l [MAXC];
   logic [5:0]  len_l [MAXC];

   // Model: at most one event in flight, described by acceptance edge, first sample edge, length.
   bit            act = 1'b0;
   bit            a_pile = 1'b0;
   int            a_f = 0, a_len = 0;
   logic          x_valid = 1'b0, x_drop = 1'b0, x_busy = 1'b0, x_pile = 1'b0;
   logic [EW-1:0] x_value = '0;
   logic [CW-1:0] x_evt = '0, x_dropc = '0;

   int d_valid_n = 0, d_drop_n = 0, d_last_valid = 0, d_last_drop = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, got, exp, m);
      end
   endtask

   task automatic summary();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
   endtask

   function automatic bit rise(input int e, input int b);
      if (e < 2) return 1'b0;
      return flg_l[e-1][b] && !flg_l[e-2][b];
   endfunction

   task automatic model_step(input bit rst);
      int acc, corr;
      if (rst) begin
         act = 0; a_pile = 0;
         x_valid = 0; x_drop = 0; x_busy = 0; x_pile = 0;
         x_value = '0; x_evt = '0; x_dropc = '0;
         return;
      end
      x_valid = 0;
      x_drop  = 0;
      if (act) begin
         if (m <= a_f + a_len - 1 && rise(m, 2)) begin
            x_drop  = 1;
            x_dropc = x_dropc + 1'b1;
            act     = 0;
         end else begin
            if (m <= a_f + a_len + 1 && (rise(m, 0) || rise(m, 1))) a_pile = 1;
            if (m == a_f + a_len + 2) begin
               acc = 0;
               for (int i = a_f; i < a_f + a_len; i++) acc += int'(adc_l[i]);
               corr = acc * 256 - a_len * int'(bl_l[a_f]);
               if (corr < 0) corr = 0;
               x_value = EW'(corr / 64);
               x_pile  = a_pile;
               x_valid = 1;
               x_evt   = x_evt + 1'b1;
               act     = 0;
            end
         end
      end else if (rise(m, 0) && len_l[m] != 6'd0) begin
         act    = 1;
         a_f    = m + int'(dly_l[m]);
         a_len  = int'(len_l[m]);
         a_pile = 0;
      end
      x_busy = act;
   endtask

   // Clock/compare process: log inputs at the edge, advance the model, check outputs 1 time unit later.
   initial begin : compare
      bit rst;
      forever begin
         @(posedge clk);
         m++;
         if (m >= MAXC) begin
            fails++;
            $display("FAIL cycle_budget: reached edge %0d, limit %0d", m, MAXC);
            summary();
            $finish;
         end
         rst = reset;
         flg_l[m] = rst ? 3'b000 : {dyn_pudump, dyn_pileup, dyn_event};
         adc_l[m] = dyn_adcdly;
         bl_l[m]  = dyn_curval;
         dly_l[m] = intdly;
         len_l[m] = intlen;
         #1;
         model_step(rst);
         chk("ene_valid", ene_valid, x_valid);
         chk("ene_drop", ene_drop, x_drop);
         chk("ene_busy", ene_busy, x_busy);
         chk("ene_value", ene_value, x_value);
         chk("ene_pileup", ene_pileup, x_pile);
         chk("evt_cnt", evt_cnt, x_evt);
         chk("drop_cnt", drop_cnt, x_dropc);
         if (ene_valid) begin d_valid_n++; d_last_valid = m; end
         if (ene_drop)  begin d_drop_n++;  d_last_drop  = m; end
      end
   end

   task automatic set_cfg(input logic [15:0] bl, input logic [7:0] adc,
                          input logic [3:0] d, input logic [5:0] l);
      @(negedge clk);
      dyn_curval = bl;
      dyn_adcdly = adc;
      intdly     = d;
      intlen     = l;
      repeat (3) @(negedge clk);
   endtask

   // Event high at edges k and k+1, low from k+2.
   task automatic fire_event(output int k);
      @(negedge clk);
      dyn_event = 1'b1;
      k = m + 1;
      @(negedge clk);
      @(negedge clk);
      dyn_event = 1'b0;
   endtask

   task automatic wait_valid(input int v0, input string nm);
      int i = 0;
      while (d_valid_n == v0 && i < 60) begin
         @(negedge clk);
         i++;
      end
      chk({nm, "_valid_seen"}, d_valid_n, v0 + 1);
   endtask

   initial begin : stimulus
      int k, v0, dr0;
      logic [CW-1:0] e0;
      repeat (3) @(negedge clk);
      chk("rst_evt_cnt", evt_cnt, 0);
      chk("rst_busy", ene_busy, 0);
      reset = 1'b0;

      // Baseline 20.0, constant 30: 8*30*256 - 8*0x1400 = 20480 -> 0x0140.
      set_cfg(16'h1400, 8'd30, 4'd0, 6'd8);
      v0 = d_valid_n;
      fire_event(k);
      wait_valid(v0, "t1");
      chk("t1_edge", d_last_valid, k + 11);
      chk("t1_value", ene_value, 16'h0140);
      chk("t1_model", x_value, 16'h0140);
      chk("t1_pileup", ene_pileup, 0);
      chk("t1_evt_cnt", evt_cnt, 1);

      // Baseline 20.5 above a constant 20: negative corr clamps to zero.
      set_cfg(16'h1480, 8'd20, 4'd0, 6'd8);
      v0 = d_valid_n;
      fire_event(k);
      wait_valid(v0, "t2");
      chk("t2_value", ene_value, 16'h0000);
      chk("t2_model", x_value, 16'h0000);

      // Ramp 10*j at edge k+j; window k+6..k+9 sums to 300 -> 1200.
      set_cfg(16'h0000, 8'd0, 4'd5, 6'd4);
      v0 = d_valid_n;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         dyn_adcdly = 8'(10 * j);
         if (j == 0) begin dyn_event = 1'b1; k = m + 1; end
         if (j == 2) dyn_event = 1'b0;
      end
      wait_valid(v0, "t3");
      chk("t3_edge", d_last_valid, k + 12);
      chk("t3_value", ene_value, 16'h04B0);

      // Second event edge three cycles into integration: one result, flagged pileup.
      set_cfg(16'h1000, 8'd50, 4'd0, 6'd16);
      v0 = d_valid_n;
      e0 = evt_cnt;
      @(negedge clk); dyn_event = 1'b1; k = m + 1;
      @(negedge clk);
      @(negedge clk); dyn_event = 1'b0;
      @(negedge clk); dyn_event = 1'b1;
      @(negedge clk);
      @(negedge clk); dyn_event = 1'b0;
      wait_valid(v0, "t4");
      chk("t4_edge", d_last_valid, k + 19);
      chk("t4_pileup", ene_pileup, 1);
      chk("t4_value", ene_value, 16'h0880);
      repeat (30) @(negedge clk);
      chk("t4_single_result", d_valid_n, v0 + 1);
      chk("t4_evt_step", evt_cnt, CW'(e0 + 1'b1));

      // Pudump seen at edge k+5 during integration aborts at edge k+6.
      set_cfg(16'h1000, 8'd40, 4'd0, 6'd16);
      v0  = d_valid_n;
      dr0 = d_drop_n;
      fire_event(k);
      repeat (3) @(negedge clk);
      dyn_pudump = 1'b1;
      for (int i = 0; i < 20 && d_drop_n == dr0; i++) @(negedge clk);
      chk("t5_drop_seen", d_drop_n, dr0 + 1);
      chk("t5_drop_edge", d_last_drop, k + 6);
      chk("t5_drop_pulse", ene_drop, 1);
      chk("t5_busy_low", ene_busy, 0);
      chk("t5_drop_cnt", drop_cnt, 1);
      dyn_pudump = 1'b0;
      @(negedge clk);
      chk("t5_drop_one_cycle", ene_drop, 0);
      repeat (30) @(negedge clk);
      chk("t5_no_valid", d_valid_n, v0);

      // Integrator disabled: events are ignored.
      set_cfg(16'h1000, 8'd40, 4'd3, 6'd0);
      v0  = d_valid_n;
      dr0 = d_drop_n;
      fire_event(k);
      repeat (3) @(negedge clk);
      chk("t6_busy", ene_busy, 0);
      repeat (20) @(negedge clk);
      chk("t6_no_valid", d_valid_n, v0);
      chk("t6_no_drop", d_drop_n, dr0);

      // Reset mid-integration clears everything and issues no strobe.
      set_cfg(16'h1000, 8'd40, 4'd0, 6'd16);
      fire_event(k);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t7_evt_cnt", evt_cnt, 0);
      chk("t7_drop_cnt", drop_cnt, 0);
      chk("t7_busy", ene_busy, 0);
      chk("t7_value", ene_value, 0);
      chk("t7_valid", ene_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      v0 = d_valid_n;
      dr0 = d_drop_n;
      repeat (40) @(negedge clk);
      chk("t7_no_valid", d_valid_n, v0);
      chk("t7_no_drop", d_drop_n, dr0);

      // Randomized traffic, including config changes mid-event and counter wrap.
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         dyn_adcdly = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0)  dyn_curval = 16'($urandom_range(0, 16'h3000));
         if ($urandom_range(0, 5) == 0)  dyn_event  = ~dyn_event;
         if ($urandom_range(0, 29) == 0) dyn_pileup = ~dyn_pileup;
         if ($urandom_range(0, 59) == 0) dyn_pudump = ~dyn_pudump;
         if ($urandom_range(0, 19) == 0) intdly = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) intlen = 6'($urandom_range(0, 24));
      end
      dyn_event  = 1'b0;
      dyn_pileup = 1'b0;
      dyn_pudump = 1'b0;
      repeat (80) @(negedge clk);
      chk("final_idle", ene_busy, 0);
      summary();
      $finish;
   end
endmodule
